boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/bl_pkg.sv | 24 ++
 rtl/bl_timeout.sv | 37 +++
 rtl/boot_loader.sv | 194 +++++++++++++++++++
 tb/tb_boot_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bl_pkg.sv
// Shared types and constants for the UART boot loader.
// BL_CHECKSUM_EN adds the CSUM state to the state enum.
package bl_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
`ifdef BL_CHECKSUM_EN
        CSUM = 3'd3,
`endif
        DONE = 3'd4,
        ERR  = 3'd5
    } bl_state_t;

    // Little-endian byte accumulation: newest byte enters at the top, so
    // after four shifts the first byte sits in bits [7:0].
    function automatic logic [31:0] le_shift_in(input logic [31:0] acc, input logic [7:0] b);
        return {b, acc[31:8]};
    endfunction

endpackage

// File: rtl/bl_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear, saturates at LIMIT.
// expired is registered-count based (asserts LIMIT cycles after clr); no backpressure.
module bl_timeout #(
    parameter int unsigned LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired = (cnt_q >= W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// UART boot loader: SYNC, 4-byte LE word count, LE data words -> instruction memory; optional XOR checksum (BL_CHECKSUM_EN).
// Write pulse one cycle after each word's 4th byte; no backpressure, every rx_valid byte is consumed.
module boot_loader
    import bl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        boot_done,
    output logic        boot_err
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

`ifdef BL_CHECKSUM_EN
    localparam bl_state_t POST_DATA = CSUM;
`else
    localparam bl_state_t POST_DATA = DONE;
`endif

    bl_state_t   state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] len_q, len_d;
    logic [31:0] word_q, word_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef BL_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic loading;
    logic expired;

`ifdef BL_CHECKSUM_EN
    assign loading = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
`else
    assign loading = (state_q == LEN) || (state_q == DATA);
`endif

    bl_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (rx_valid || !loading),
        .en      (loading),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef BL_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            IDLE, ERR: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d    = LEN;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 32'd0;
                    len_d      = 32'd0;
                    word_d     = 32'd0;
`ifdef BL_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end

            LEN: begin
                if (expired) begin
                    state_d = ERR;
                end else if (rx_valid) begin
                    len_d      = le_shift_in(len_q, rx_data);
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef BL_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        if (len_d > MEM_WORDS_W) begin
                            state_d = ERR;
                        end else if (len_d == 32'd0) begin
                            state_d = POST_DATA;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end

            DATA: begin
                // The FSM stays in DATA through the last write pulse; a byte
                // arriving in that same cycle is the checksum byte.
                if (mem_we_q && (word_cnt_q == len_q)) begin
`ifdef BL_CHECKSUM_EN
                    if (rx_valid) begin
                        state_d = (rx_data == csum_q) ? DONE : ERR;
                    end else begin
                        state_d = CSUM;
                    end
`else
                    state_d = DONE;
`endif
                end else if (expired) begin
                    state_d = ERR;
                end else if (rx_valid) begin
                    word_d     = le_shift_in(word_q, rx_data);
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef BL_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR + {word_cnt_q[29:0], 2'b00};
                        mem_wdata_d = word_d;
                        word_cnt_d  = word_cnt_q + 32'd1;
                    end
                end
            end

`ifdef BL_CHECKSUM_EN
            CSUM: begin
                if (expired) begin
                    state_d = ERR;
                end else if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? DONE : ERR;
                end
            end
`endif

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 2'd0;
            word_cnt_q  <= 32'd0;
            len_q       <= 32'd0;
            word_q      <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'd0;
`ifdef BL_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef BL_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = (state_q != DONE);
    assign boot_done = (state_q == DONE);
    assign boot_err  = (state_q == ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes queued with stimulus, popped on mem_we.
// Covers reset, normal/garbage/back-to-back loads, size limits, timeout, mid-load reset, checksum.
module tb_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MW   = 16;
    localparam int          TO   = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        boot_done;
    logic        boot_err;

    boot_loader #(
        .BASE_ADDR      (BASE),
        .MEM_WORDS      (MW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_wr = 0;
    logic [63:0] sb_q[$];
    logic [7:0]  stim_q[$];
    logic [31:0] w_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_wr++;
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e[63:32]));
                check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
            end
        end
    end

    // Builds SYNC + length + words from w_q + checksum, queuing expected writes.
    task automatic build(input logic [31:0] n, input bit good_csum);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        stim_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            b = n[8*i +: 8];
            stim_q.push_back(b);
            cs ^= b;
        end
        for (int k = 0; k < w_q.size(); k++) begin
            for (int i = 0; i < 4; i++) begin
                b = w_q[k][8*i +: 8];
                stim_q.push_back(b);
                cs ^= b;
            end
            sb_q.push_back({BASE + 32'(4 * k), w_q[k]});
        end
        stim_q.push_back(good_csum ? cs : (cs ^ 8'hFF));
    endtask

    task automatic drive(input bit b2b);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            rx_data  = stim_q.pop_front();
            rx_valid = 1'b1;
            if (!b2b) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic two_words();
        w_q.delete();
        w_q.push_back(32'h0000_0013);
        w_q.push_back(32'h0010_0093);
    endtask

    task automatic check_done(input string tag, input int wr0, input int nw);
        repeat (3) @(negedge clk);
        check({tag, "_done"}, 64'(boot_done), 64'd1);
        check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
        check({tag, "_err"}, 64'(boot_err), 64'd0);
        check({tag, "_nwr"}, 64'(n_wr - wr0), 64'(nw));
        check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int wr0;
        repeat (2) @(negedge clk);
        check("rst_hold", 64'(cpu_hold), 64'd1);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'(BASE));
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_done", 64'(boot_done), 64'd0);
        check("rst_err", 64'(boot_err), 64'd0);
        reset = 1'b0;

        // Basic two-word load
        wr0 = n_wr;
        two_words();
        build(32'd2, 1'b1);
        drive(1'b0);
        check_done("load", wr0, 2);

        // Bytes after DONE are ignored
        wr0 = n_wr;
        stim_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        drive(1'b0);
        repeat (3) @(negedge clk);
        check("done_ignore_nwr", 64'(n_wr - wr0), 64'd0);
        check("done_ignore_done", 64'(boot_done), 64'd1);

        // Leading garbage, back-to-back bytes (rx_valid during mem_we)
        do_reset();
        wr0 = n_wr;
        stim_q.push_back(8'h00);
        stim_q.push_back(8'hFF);
        two_words();
        build(32'd2, 1'b1);
        drive(1'b1);
        check_done("garbage_b2b", wr0, 2);

        // Oversize, then recovery from ERR
        do_reset();
        wr0 = n_wr;
        stim_q = '{8'hA5, 8'(MW + 1), 8'h00, 8'h00, 8'h00};
        drive(1'b0);
        repeat (3) @(negedge clk);
        check("over_err", 64'(boot_err), 64'd1);
        check("over_hold", 64'(cpu_hold), 64'd1);
        check("over_nwr", 64'(n_wr - wr0), 64'd0);
        two_words();
        build(32'd2, 1'b1);
        drive(1'b0);
        check_done("recover", wr0, 2);

        // Exactly MEM_WORDS words
        do_reset();
        wr0 = n_wr;
        w_q.delete();
        for (int k = 0; k < MW; k++) w_q.push_back($urandom());
        build(32'(MW), 1'b1);
        drive(1'b1);
        check_done("full", wr0, MW);

        // Zero-length load
        do_reset();
        wr0 = n_wr;
        w_q.delete();
        build(32'd0, 1'b1);
        drive(1'b0);
        check_done("zero", wr0, 0);

        // Timeout mid-word
        do_reset();
        wr0 = n_wr;
        stim_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
        drive(1'b0);
        repeat (TO - 3) @(negedge clk);
        check("to_early_err", 64'(boot_err), 64'd0);
        repeat (4) @(negedge clk);
        check("to_err", 64'(boot_err), 64'd1);
        check("to_hold", 64'(cpu_hold), 64'd1);
        check("to_nwr", 64'(n_wr - wr0), 64'd0);

        // Reset during DATA after word 0
        do_reset();
        wr0 = n_wr;
        stim_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        sb_q.push_back({BASE, 32'h0000_0013});
        drive(1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_we", 64'(mem_we), 64'd0);
        check("midrst_addr", 64'(mem_addr), 64'(BASE));
        check("midrst_wdata", 64'(mem_wdata), 64'd0);
        check("midrst_hold", 64'(cpu_hold), 64'd1);
        check("midrst_done", 64'(boot_done), 64'd0);
        check("midrst_err", 64'(boot_err), 64'd0);
        reset = 1'b0;
        stim_q = '{8'h10, 8'h00, 8'h00, 8'h00};
        drive(1'b0);
        repeat (3) @(negedge clk);
        check("midrst_nwr", 64'(n_wr - wr0), 64'd1);
        check("midrst_idle_done", 64'(boot_done), 64'd0);

`ifdef BL_CHECKSUM_EN
        // Bad checksum: words still written, load ends in ERR
        do_reset();
        wr0 = n_wr;
        two_words();
        build(32'd2, 1'b0);
        drive(1'b0);
        repeat (3) @(negedge clk);
        check("badcs_err", 64'(boot_err), 64'd1);
        check("badcs_hold", 64'(cpu_hold), 64'd1);
        check("badcs_nwr", 64'(n_wr - wr0), 64'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
